// File: rtl/ret_stack_pkg.sv
// Shared CPU constants for the return-address stack, plus the decoded
// stack operation type.
package ret_stack_pkg;

  localparam int unsigned PcWidth       = 10;
  localparam int unsigned RetStackDepth = 8;

  typedef enum logic [2:0] {
    OpIdle,
    OpPush,
    OpPop,
    OpReplace,
    OpPushEmpty,
    OpRefusePush,
    OpRefusePop
  } stack_op_e;

endpackage

// File: rtl/ret_stack_mem.sv
// Return-stack storage: DEPTH x WIDTH registers, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module ret_stack_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop decode, registered pointer and sticky error
// flags. All outputs are derived from registered state only.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int unsigned WIDTH = PcWidth,
  parameter int unsigned DEPTH = RetStackDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_addr,
  output logic [WIDTH-1:0]       top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  stack_op_e        op;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  // Wraps to DEPTH-1 when empty; the read is masked by is_empty below.
  assign raddr    = AW'(count_q - CW'(1));

  always_comb begin
    op = OpIdle;
    unique case ({push, pop})
      2'b10:   op = is_full  ? OpRefusePush : OpPush;
      2'b01:   op = is_empty ? OpRefusePop  : OpPop;
      2'b11:   op = is_empty ? OpPushEmpty  : OpReplace;
      default: op = OpIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
    unique case (op)
      OpPush: begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
      end
      OpPop:        count_d = count_q - CW'(1);
      OpReplace: begin
        we    = 1'b1;
        waddr = raddr;
      end
      OpPushEmpty: begin
        we      = 1'b1;
        waddr   = '0;
        count_d = CW'(1);
        unf_d   = 1'b1;
      end
      OpRefusePush: ovf_d = 1'b1;
      OpRefusePop:  unf_d = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ret_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (push_addr),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign top       = is_empty ? '0 : rdata;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Randomized bench for ret_stack against a queue-based LIFO reference model,
// preceded by directed scenarios for the documented corner cases.
module tb_ret_stack;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       push_addr;
  logic [WIDTH-1:0]       top;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;
  logic                   overflow;
  logic                   underflow;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned m_stack[$];
  bit          m_ovf;
  bit          m_unf;

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit p, input bit o, input int unsigned a);
    if (!r) begin
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && o) begin
      if (m_stack.size() == 0) begin
        m_stack.push_back(a);
        m_unf = 1'b1;
      end else begin
        m_stack[m_stack.size() - 1] = a;
      end
    end else if (p) begin
      if (m_stack.size() == DEPTH) m_ovf = 1'b1;
      else m_stack.push_back(a);
    end else if (o) begin
      if (m_stack.size() == 0) m_unf = 1'b1;
      else void'(m_stack.pop_back());
    end
  endtask

  task automatic check_outputs();
    int unsigned exp_top;
    exp_top = (m_stack.size() == 0) ? 0 : m_stack[m_stack.size() - 1];
    check_eq("top",       32'(top),       exp_top);
    check_eq("count",     32'(count),     m_stack.size());
    check_eq("empty",     32'(empty),     32'(m_stack.size() == 0));
    check_eq("full",      32'(full),      32'(m_stack.size() == DEPTH));
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
    check_eq("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input bit r, input bit p, input bit o, input logic [WIDTH-1:0] a);
    reset     = r;
    push      = p;
    pop       = o;
    push_addr = a;
    @(posedge clk);
    #1;
    model_step(r, p, o, 32'(a));
    check_outputs();
  endtask

  initial begin
    bit          p, o, r;
    bit          fill_phase;
    int unsigned bias;

    m_ovf = 1'b0;
    m_unf = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 10'h155);
    check_eq("reset_count", 32'(count), 32'd0);
    check_eq("reset_empty", 32'(empty), 32'd1);

    // Three pushes then three pops, no flags.
    step(1'b1, 1'b1, 1'b0, 10'h005);
    step(1'b1, 1'b1, 1'b0, 10'h0A3);
    step(1'b1, 1'b1, 1'b0, 10'h3FF);
    check_eq("seq_top3", 32'(top), 32'h3FF);
    step(1'b1, 1'b0, 1'b1, '0);
    check_eq("seq_pop1", 32'(top), 32'h0A3);
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    check_eq("seq_empty_top", 32'(top), 32'h0);

    // Fill to DEPTH and push once more.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 10'(i));
    step(1'b1, 1'b1, 1'b0, 10'h100);
    check_eq("full_top", 32'(top), 32'h008);
    check_eq("full_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 1'b1, '0);
    check_eq("full_pop_top", 32'(top), 32'h007);
    // Push+pop while full replaces top without overflow change.
    step(1'b1, 1'b1, 1'b0, 10'h009);
    step(1'b1, 1'b1, 1'b1, 10'h1C1);

    // Underflow from empty, then push.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b0, 10'h020);
    check_eq("unf_sticky", 32'(underflow), 32'd1);

    // Replace at count=2.
    step(1'b1, 1'b1, 1'b0, 10'h011);
    step(1'b1, 1'b1, 1'b1, 10'h2AA);
    check_eq("replace_top", 32'(top), 32'h2AA);
    step(1'b1, 1'b0, 1'b1, '0);
    check_eq("replace_pop", 32'(top), 32'h020);

    // count=5 with both flags set, then reset with push.
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 10'h040);
    check_eq("pe_top", 32'(top), 32'h040);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 10'(32'h50 + i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, 10'h3AB);
    check_eq("rst_count", 32'(count), 32'd0);
    step(1'b1, 1'b1, 1'b0, 10'h2B2);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    fill_phase = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (c % 37 == 0) fill_phase = ~fill_phase;
      bias = fill_phase ? 70 : 30;
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      r = ($urandom_range(0, 99) != 0);
      step(r, p, o, 10'($urandom_range(0, 1023)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
